// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             msb,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic             qbit
);

    logic [WIDTH:0] trial;

    // Trial keeps the full shifted remainder so the compare never wraps.
    assign trial    = {rem, msb};
    assign qbit     = (trial >= {1'b0, divisor});
    assign rem_next = qbit ? (trial[WIDTH-1:0] - divisor) : trial[WIDTH-1:0];

endmodule

// File: rtl/div_seq.sv
// Iterative unsigned divider, one quotient bit per clock, beside the multiplier.
//   state  | meaning
//   S_IDLE | waiting for start; results from the last division held
//   S_RUN  | WIDTH restoring steps, counter counts down to 0
//   S_FIN  | one-cycle done pulse, results valid
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] rem_next;
    logic             qbit;
    logic             accept;
    logic             last_step;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .msb      (shift[WIDTH-1]),
        .divisor  (dvsr),
        .rem_next (rem_next),
        .qbit     (qbit)
    );

    assign accept    = (state == S_IDLE) && start;
    assign last_step = (state == S_RUN) && (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = (divisor == '0) ? S_FIN : S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = S_FIN;
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Results are loaded on the edge entering S_FIN so they are valid with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            shift       <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            cnt   <= CW'(WIDTH - 1);
            rem   <= '0;
            shift <= dividend;
            dvsr  <= divisor;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                quotient    <= '0;
                remainder   <= '0;
                div_by_zero <= 1'b0;
            end
        end else if (state == S_RUN) begin
            rem   <= rem_next;
            shift <= {shift[WIDTH-2:0], qbit};
            cnt   <= cnt - CW'(1);
            if (last_step) begin
                quotient  <= {shift[WIDTH-2:0], qbit};
                remainder <= rem_next;
            end
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed-vector bench for div_seq at WIDTH=32.
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    div_seq #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Pulse start for one edge, then watch `window` cycles (cycle 1 follows the accept edge).
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int window,
                         output int lat, output int nbusy, output int ndone,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1; nbusy = 0; ndone = 0; q = '0; r = '0; z = 1'b0;
        for (int c = 1; c <= window; c++) begin
            if (busy) nbusy++;
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = c; q = quotient; r = remainder; z = div_by_zero;
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        vectors++; if (quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got %h want 0", quotient); end
        vectors++; if (remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got %h want 0", remainder); end
        vectors++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        int lat, nb, nd; logic [31:0] q, r; logic z;
        do_op(32'd1234321, 32'd1111, 36, lat, nb, nd, q, r, z);
        vectors++; if (lat !== 33) begin errors++; $display("FAIL basic_latency got %0d want 33", lat); end
        vectors++; if (nb !== 32) begin errors++; $display("FAIL basic_busy_cycles got %0d want 32", nb); end
        vectors++; if (nd !== 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", nd); end
        vectors++; if (q !== 32'd1111) begin errors++; $display("FAIL basic_quotient got %0d want 1111", q); end
        vectors++; if (r !== 32'd0) begin errors++; $display("FAIL basic_remainder got %0d want 0", r); end
        vectors++; if (z !== 1'b0) begin errors++; $display("FAIL basic_dbz got %b want 0", z); end
        vectors++; if (quotient !== 32'd1111) begin errors++; $display("FAIL basic_hold got %0d want 1111", quotient); end
    endtask

    task automatic test_div_zero;
        int lat, nb, nd; logic [31:0] q, r; logic z;
        do_op(32'd1111, 32'd0, 6, lat, nb, nd, q, r, z);
        vectors++; if (lat !== 1) begin errors++; $display("FAIL dbz_latency got %0d want 1", lat); end
        vectors++; if (nb !== 0) begin errors++; $display("FAIL dbz_busy_cycles got %0d want 0", nb); end
        vectors++; if (nd !== 1) begin errors++; $display("FAIL dbz_done_count got %0d want 1", nd); end
        vectors++; if (q !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_quotient got %h want ffffffff", q); end
        vectors++; if (r !== 32'd1111) begin errors++; $display("FAIL dbz_remainder got %0d want 1111", r); end
        vectors++; if (z !== 1'b1) begin errors++; $display("FAIL dbz_flag got %b want 1", z); end
        vectors++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag_hold got %b want 1", div_by_zero); end
    endtask

    task automatic test_boundary;
        logic [31:0] tv_a [5] = '{32'hFFFF_FFFF, 32'd100,    32'd0,    32'hFFFF_FFFF, 32'd1000};
        logic [31:0] tv_b [5] = '{32'd1,        32'd505000, 32'd1111, 32'hFFFF_FFFE, 32'd7};
        logic [31:0] tv_q [5] = '{32'hFFFF_FFFF, 32'd0,     32'd0,    32'd1,         32'd142};
        logic [31:0] tv_r [5] = '{32'd0,        32'd100,    32'd0,    32'd1,         32'd6};
        int lat, nb, nd; logic [31:0] q, r; logic z;
        for (int i = 0; i < 5; i++) begin
            do_op(tv_a[i], tv_b[i], 36, lat, nb, nd, q, r, z);
            vectors++; if (lat !== 33) begin errors++; $display("FAIL bnd%0d_latency got %0d want 33", i, lat); end
            vectors++; if (q !== tv_q[i]) begin errors++; $display("FAIL bnd%0d_quotient got %h want %h", i, q, tv_q[i]); end
            vectors++; if (r !== tv_r[i]) begin errors++; $display("FAIL bnd%0d_remainder got %h want %h", i, r, tv_r[i]); end
            vectors++; if (z !== 1'b0) begin errors++; $display("FAIL bnd%0d_dbz got %b want 0", i, z); end
        end
    endtask

    task automatic test_ignore_start;
        int nd = 0;
        int lat = -1;
        logic [31:0] q = '0;
        logic [31:0] r = '0;
        @(negedge clk);
        dividend = 32'd1111111111; divisor = 32'd22; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 10) begin start = 1'b1; dividend = 32'd7; divisor = 32'd2; end
            if (c == 11) start = 1'b0;
            if (done) begin
                nd++;
                if (lat < 0) begin lat = c; q = quotient; r = remainder; end
            end
            @(negedge clk);
        end
        vectors++; if (nd !== 1) begin errors++; $display("FAIL ign_done_count got %0d want 1", nd); end
        vectors++; if (lat !== 33) begin errors++; $display("FAIL ign_latency got %0d want 33", lat); end
        vectors++; if (q !== 32'd50505050) begin errors++; $display("FAIL ign_quotient got %0d want 50505050", q); end
        vectors++; if (r !== 32'd11) begin errors++; $display("FAIL ign_remainder got %0d want 11", r); end
        vectors++; if (quotient !== 32'd50505050) begin errors++; $display("FAIL ign_hold got %0d want 50505050", quotient); end
    endtask

    task automatic test_reset_mid;
        int nd = 0;
        int lat, nb, nd2; logic [31:0] q, r; logic z;
        @(negedge clk);
        dividend = 32'd505000; divisor = 32'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 15; c++) begin
            if (done) nd++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got %b want 0", done); end
        vectors++; if (quotient !== 32'd0) begin errors++; $display("FAIL mid_rst_quotient got %h want 0", quotient); end
        vectors++; if (remainder !== 32'd0) begin errors++; $display("FAIL mid_rst_remainder got %h want 0", remainder); end
        vectors++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL mid_rst_dbz got %b want 0", div_by_zero); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (done) nd++;
            @(negedge clk);
        end
        vectors++; if (nd !== 0) begin errors++; $display("FAIL mid_rst_no_done got %0d want 0", nd); end
        do_op(32'd505000, 32'd100, 36, lat, nb, nd2, q, r, z);
        vectors++; if (lat !== 33) begin errors++; $display("FAIL mid_after_latency got %0d want 33", lat); end
        vectors++; if (q !== 32'd5050) begin errors++; $display("FAIL mid_after_quotient got %0d want 5050", q); end
        vectors++; if (r !== 32'd0) begin errors++; $display("FAIL mid_after_remainder got %0d want 0", r); end
    endtask

    task automatic test_back_to_back;
        int nd = 0;
        int last = 0;
        @(negedge clk);
        dividend = 32'd111; divisor = 32'd22; start = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 105; c++) begin
            if (done) begin
                nd++;
                vectors++;
                if (c - last !== ((nd == 1) ? 33 : 34)) begin
                    errors++; $display("FAIL b2b_spacing%0d got %0d want %0d", nd, c - last, (nd == 1) ? 33 : 34);
                end
                vectors++; if (quotient !== 32'd5) begin errors++; $display("FAIL b2b_quotient%0d got %0d want 5", nd, quotient); end
                vectors++; if (remainder !== 32'd1) begin errors++; $display("FAIL b2b_remainder%0d got %0d want 1", nd, remainder); end
                last = c;
            end
            @(negedge clk);
        end
        start = 1'b0;
        vectors++; if (nd !== 3) begin errors++; $display("FAIL b2b_done_count got %0d want 3", nd); end
        repeat (40) @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_div_zero;
        test_boundary;
        test_ignore_start;
        test_reset_mid;
        test_back_to_back;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
